// File: rtl/rp_8bit_io_tmr_pkg.sv
// rp_8bit_io_tmr_pkg
// Shared definitions for the rp_8bit I/O timer/counter peripheral.
// It holds:
//   - register offsets within the 8-register I/O window
//   - the clock-select encoding
//   - bit positions of the control, mask and flag bits
//   - the TCCR layout
//   - helpers that map a clock select to the prescaler terminal count
package rp_8bit_io_tmr_pkg;

  // Register offsets, selected by io_adr[2:0]
  localparam logic [2:0] OFF_TCCR  = 3'd0;
  localparam logic [2:0] OFF_TCNT  = 3'd1;
  localparam logic [2:0] OFF_OCR   = 3'd2;
  localparam logic [2:0] OFF_TIMSK = 3'd3;
  localparam logic [2:0] OFF_TIFR  = 3'd4;

  // Clock select. Encodings 6 and 7 are not listed and behave like STOP.
  typedef enum logic [2:0] {
    STOP    = 3'd0,
    DIV1    = 3'd1,
    DIV8    = 3'd2,
    DIV64   = 3'd3,
    DIV256  = 3'd4,
    DIV1024 = 3'd5
  } cs_e;

  // Bit positions
  localparam int CTC_BIT  = 3;
  localparam int OCIE_BIT = 0;
  localparam int TOIE_BIT = 1;
  localparam int OCF_BIT  = 0;
  localparam int TOVF_BIT = 1;

  // TCCR layout. The upper nibble is reserved and always reads 0.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       ctc;
    logic [2:0] cs;
  } tccr_t;

  // The prescaler wraps, and emits a tick, when its count reaches div-1.
  function automatic logic [9:0] prescale_term(input logic [2:0] cs);
    logic [9:0] term;
    case (cs)
      DIV8:    term = 10'd7;
      DIV64:   term = 10'd63;
      DIV256:  term = 10'd255;
      DIV1024: term = 10'd1023;
      default: term = 10'd0;
    endcase
    return term;
  endfunction

  // The timer only runs for the five divide settings.
  function automatic logic cs_running(input logic [2:0] cs);
    return (cs >= DIV1) && (cs <= DIV1024);
  endfunction

endpackage

// File: rtl/rp_8bit_io_prescaler.sv
// rp_8bit_io_prescaler
// Free-running clock prescaler for the timer. It emits a one-cycle tick
// every div clocks, with div selected by the clock select input.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous reset, active-low
//   cs_i    clock select (current TCCR.CS)
//   clr_i   synchronous clear; forces the count to 0 and suppresses the tick
//   tick_o  advance-the-timer strobe (combinational from the registered count)
module rp_8bit_io_prescaler
  import rp_8bit_io_tmr_pkg::*;
#(
  parameter int PSW = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] cs_i,
  input  logic       clr_i,
  output logic       tick_o
);

  logic [PSW-1:0] cnt_q, cnt_d;
  logic [PSW-1:0] term;

  assign term = PSW'(prescale_term(cs_i));

  // The count is held at zero while stopped or cleared.
  // Otherwise it wraps at the terminal value and fires a tick there.
  // A clear takes priority, so a CS change never produces a stray tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i || !cs_running(cs_i)) begin
      cnt_d = '0;
    end else if (cnt_q == term) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + PSW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rp_8bit_io_tmr.sv
// rp_8bit_io_tmr
// 8-bit timer/counter peripheral on the rp_8bit I/O bus. It provides:
//   - a prescaled up-counter with output-compare match, optional CTC
//     (clear on compare) and overflow detection
//   - two level interrupt requests, each cleared by irq_ack or by a
//     write-1-to-clear of TIFR
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   io_wen/io_ren write / read enables
//   io_adr        I/O address; the window is BASE[5:3], the register is io_adr[2:0]
//   io_wdt/io_msk write data and per-bit write mask
//   io_rdt        registered read data; 0 when not addressed, so it can be OR-combined
//   irq_req       [0] compare match, [1] overflow
//   irq_ack       per-bit acknowledge pulses from the core
module rp_8bit_io_tmr
  import rp_8bit_io_tmr_pkg::*;
#(
  parameter logic [5:0] BASE = 6'h30,
  parameter int         PSW  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic [1:0] irq_req,
  input  logic [1:0] irq_ack
);

  tccr_t      tccr_q, tccr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] ocr_q, ocr_d;
  logic [1:0] timsk_q, timsk_d;
  logic [1:0] tifr_q, tifr_d;
  logic [7:0] rdt_q, rdt_d;

  logic       hit;
  logic [2:0] off;
  logic       wr_tccr, wr_tcnt, wr_ocr, wr_timsk, wr_tifr;
  logic       tick, psc_clr;
  logic       ocf_set, tovf_set;
  logic [1:0] flag_set, flag_clr;

  assign hit      = (io_adr[5:3] == BASE[5:3]);
  assign off      = io_adr[2:0];
  assign wr_tccr  = io_wen && hit && (off == OFF_TCCR);
  assign wr_tcnt  = io_wen && hit && (off == OFF_TCNT);
  assign wr_ocr   = io_wen && hit && (off == OFF_OCR);
  assign wr_timsk = io_wen && hit && (off == OFF_TIMSK);
  assign wr_tifr  = io_wen && hit && (off == OFF_TIFR);

  // Masked write of TCCR. The reserved nibble is never stored.
  always_comb begin
    tccr_d = tccr_q;
    if (wr_tccr) begin
      tccr_d.ctc = (io_wdt[CTC_BIT] & io_msk[CTC_BIT]) | (tccr_q.ctc & ~io_msk[CTC_BIT]);
      tccr_d.cs  = (io_wdt[2:0] & io_msk[2:0]) | (tccr_q.cs & ~io_msk[2:0]);
    end
    tccr_d.rsvd = 4'b0;
  end

  // Restart the prescaler whenever the clock select actually changes.
  // This keeps the first period after a rate change a full period.
  assign psc_clr = wr_tccr && (tccr_d.cs != tccr_q.cs);

  rp_8bit_io_prescaler #(
    .PSW(PSW)
  ) u_prescaler (
    .clk_i (clk),
    .rst_ni(rst),
    .cs_i  (tccr_q.cs),
    .clr_i (psc_clr),
    .tick_o(tick)
  );

  // Counter update.
  //   - A CPU write to TCNT wins over the tick, and that tick raises no events.
  //   - A tick compares the pre-tick count against the current OCR. A
  //     same-cycle OCR write only takes effect afterwards.
  //   - In CTC mode a match clears the count. This also covers OCR=FF, so
  //     no overflow is reported in that case.
  always_comb begin
    tcnt_d   = tcnt_q;
    ocf_set  = 1'b0;
    tovf_set = 1'b0;
    if (wr_tcnt) begin
      tcnt_d = (io_wdt & io_msk) | (tcnt_q & ~io_msk);
    end else if (tick) begin
      ocf_set = (tcnt_q == ocr_q);
      if (ocf_set && tccr_q.ctc) begin
        tcnt_d = 8'h00;
      end else if (tcnt_q == 8'hFF) begin
        tcnt_d   = 8'h00;
        tovf_set = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end
  end

  // OCR and TIMSK use a plain masked write.
  always_comb begin
    ocr_d   = ocr_q;
    timsk_d = timsk_q;
    if (wr_ocr) begin
      ocr_d = (io_wdt & io_msk) | (ocr_q & ~io_msk);
    end
    if (wr_timsk) begin
      timsk_d = (io_wdt[1:0] & io_msk[1:0]) | (timsk_q & ~io_msk[1:0]);
    end
  end

  // Flags are cleared by write-1 or by irq_ack.
  // A hardware set in the same cycle wins, so no event is lost.
  always_comb begin
    flag_set           = 2'b00;
    flag_set[OCF_BIT]  = ocf_set;
    flag_set[TOVF_BIT] = tovf_set;
    flag_clr           = irq_ack;
    if (wr_tifr) begin
      flag_clr = flag_clr | (io_wdt[1:0] & io_msk[1:0]);
    end
    tifr_d = (tifr_q & ~flag_clr) | flag_set;
  end

  // Read mux. It returns pre-write values, and 0 whenever the window is
  // not being read, so the bus can be OR-combined.
  always_comb begin
    rdt_d = 8'h00;
    if (io_ren && hit) begin
      case (off)
        OFF_TCCR:  rdt_d = tccr_q;
        OFF_TCNT:  rdt_d = tcnt_q;
        OFF_OCR:   rdt_d = ocr_q;
        OFF_TIMSK: rdt_d = {6'b0, timsk_q};
        OFF_TIFR:  rdt_d = {6'b0, tifr_q};
        default:   rdt_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tccr_q  <= '0;
      tcnt_q  <= 8'h00;
      ocr_q   <= 8'h00;
      timsk_q <= 2'b00;
      tifr_q  <= 2'b00;
      rdt_q   <= 8'h00;
    end else begin
      tccr_q  <= tccr_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      timsk_q <= timsk_d;
      tifr_q  <= tifr_d;
      rdt_q   <= rdt_d;
    end
  end

  assign io_rdt  = rdt_q;
  assign irq_req = tifr_q & timsk_q;

endmodule

// File: tb/tb_rp_8bit_io_tmr.sv
// tb_rp_8bit_io_tmr
// Directed testbench for rp_8bit_io_tmr. Bus cycles are driven on the
// falling edge and outputs are sampled on the following falling edge, so
// each bus cycle spans exactly one rising edge.
module tb_rp_8bit_io_tmr;

  localparam logic [5:0] A_TCCR  = 6'h30;
  localparam logic [5:0] A_TCNT  = 6'h31;
  localparam logic [5:0] A_OCR   = 6'h32;
  localparam logic [5:0] A_TIMSK = 6'h33;
  localparam logic [5:0] A_TIFR  = 6'h34;

  logic       clk;
  logic       rst;
  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;
  logic [1:0] irq_req;
  logic [1:0] irq_ack;

  int checks   = 0;
  int failures = 0;

  rp_8bit_io_tmr #(
    .BASE(6'h30),
    .PSW (10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_wen (io_wen),
    .io_ren (io_ren),
    .io_adr (io_adr),
    .io_wdt (io_wdt),
    .io_msk (io_msk),
    .io_rdt (io_rdt),
    .irq_req(irq_req),
    .irq_ack(irq_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every comparison and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle (one rising edge) and then returns the bus to idle.
  task automatic applyStimulus(input logic wen, input logic ren, input logic [5:0] adr,
                               input logic [7:0] wdt, input logic [7:0] msk,
                               input logic [1:0] ack);
    io_wen  = wen;
    io_ren  = ren;
    io_adr  = adr;
    io_wdt  = wdt;
    io_msk  = msk;
    irq_ack = ack;
    @(negedge clk);
    io_wen  = 1'b0;
    io_ren  = 1'b0;
    io_adr  = 6'h00;
    io_wdt  = 8'h00;
    io_msk  = 8'h00;
    irq_ack = 2'b00;
  endtask

  task automatic ioWrite(input logic [5:0] adr, input logic [7:0] wdt);
    applyStimulus(1'b1, 1'b0, adr, wdt, 8'hFF, 2'b00);
  endtask

  task automatic ioRead(input logic [5:0] adr, output logic [7:0] d);
    applyStimulus(1'b0, 1'b1, adr, 8'h00, 8'h00, 2'b00);
    d = io_rdt;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    rst     = 1'b1;
    io_wen  = 1'b0;
    io_ren  = 1'b0;
    io_adr  = 6'h00;
    io_wdt  = 8'h00;
    io_msk  = 8'h00;
    irq_ack = 2'b00;
    #3 rst = 1'b0;
    #1;
    checkOutput("reset_rdt", io_rdt, 8'h00);
    checkOutput("reset_irq", {6'b0, irq_req}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // All eight registers read back zero after reset.
    for (int i = 0; i < 8; i++) begin
      ioRead(6'h30 + 6'(i), d);
      checkOutput($sformatf("reset_reg%0d", i), d, 8'h00);
    end

    // Basic readback, out-of-window read and a read after a non-read.
    ioWrite(A_OCR, 8'h5A);
    ioRead(A_OCR, d);
    checkOutput("ocr_readback", d, 8'h5A);
    idleCycles(1);
    checkOutput("rdt_after_idle", io_rdt, 8'h00);
    ioRead(6'h38, d);
    checkOutput("read_miss", d, 8'h00);
    // A read colliding with a write returns the pre-write value.
    applyStimulus(1'b1, 1'b1, A_OCR, 8'h77, 8'hFF, 2'b00);
    checkOutput("read_during_write", io_rdt, 8'h5A);
    ioRead(A_OCR, d);
    checkOutput("ocr_after_collide", d, 8'h77);

    // Masked write: only CTC lands; the timer stays stopped.
    applyStimulus(1'b1, 1'b0, A_TCCR, 8'hFF, 8'h08, 2'b00);
    ioRead(A_TCCR, d);
    checkOutput("tccr_masked", d, 8'h08);
    idleCycles(5);
    ioRead(A_TCNT, d);
    checkOutput("tcnt_stopped", d, 8'h00);
    ioWrite(A_TCCR, 8'h00);

    // Overflow from FE with divide-by-1.
    ioWrite(A_TIMSK, 8'h02);
    ioWrite(A_TCNT, 8'hFE);
    ioWrite(A_TCCR, 8'h01);
    idleCycles(1);
    checkOutput("ovf_irq_before", {6'b0, irq_req}, 8'h00);
    idleCycles(1);
    checkOutput("ovf_irq", {6'b0, irq_req}, 8'h02);
    ioWrite(A_TCCR, 8'h00);
    ioRead(A_TCNT, d);
    checkOutput("ovf_tcnt", d, 8'h00);
    ioRead(A_TIFR, d);
    checkOutput("ovf_tifr", d, 8'h02);
    applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 2'b10);
    checkOutput("ack_irq", {6'b0, irq_req}, 8'h00);
    ioRead(A_TIFR, d);
    checkOutput("ack_tifr", d, 8'h00);

    // CTC at divide-by-8 with OCR=3: the match lands 32 clocks after the TCCR write.
    ioWrite(A_OCR, 8'h03);
    ioWrite(A_TIMSK, 8'h01);
    ioWrite(A_TCCR, 8'h0A);
    for (int k = 1; k <= 34; k++) begin
      ioRead(A_TCNT, d);
      if (k == 4)  checkOutput("ctc_tcnt0", d, 8'h00);
      if (k == 12) checkOutput("ctc_tcnt1", d, 8'h01);
      if (k == 20) checkOutput("ctc_tcnt2", d, 8'h02);
      if (k == 28) checkOutput("ctc_tcnt3", d, 8'h03);
      if (k == 31) checkOutput("ctc_irq_early", {6'b0, irq_req}, 8'h00);
      if (k == 32) checkOutput("ctc_irq_32", {6'b0, irq_req}, 8'h01);
      if (k == 33) checkOutput("ctc_tcnt_wrap", d, 8'h00);
    end
    ioWrite(A_TCCR, 8'h08);
    ioRead(A_TIFR, d);
    checkOutput("ctc_tifr", d, 8'h01);
    ioWrite(A_TIFR, 8'h01);
    ioRead(A_TIFR, d);
    checkOutput("w1c_tifr", d, 8'h00);
    checkOutput("w1c_irq", {6'b0, irq_req}, 8'h00);

    // A TCNT write beats the wrap tick, so no overflow is raised.
    ioWrite(A_TCNT, 8'hFF);
    ioWrite(A_TCCR, 8'h01);
    ioWrite(A_TCNT, 8'h10);
    ioWrite(A_TCCR, 8'h00);
    ioRead(A_TCNT, d);
    checkOutput("coll_tcnt", d, 8'h10);
    ioRead(A_TIFR, d);
    checkOutput("coll_no_tovf", d, 8'h00);

    // A compare set beats a same-cycle write-1-clear.
    ioWrite(A_TCNT, 8'h03);
    ioWrite(A_TCCR, 8'h01);
    ioWrite(A_TIFR, 8'h01);
    ioWrite(A_TCCR, 8'h00);
    ioRead(A_TIFR, d);
    checkOutput("set_beats_clr", d, 8'h01);
    checkOutput("set_beats_clr_irq", {6'b0, irq_req}, 8'h01);
    ioRead(A_TCNT, d);
    checkOutput("set_beats_clr_tcnt", d, 8'h04);
    ioWrite(A_TIFR, 8'h01);

    // Asynchronous reset in the middle of a count.
    ioWrite(A_TCNT, 8'hFE);
    ioWrite(A_TIMSK, 8'h03);
    ioWrite(A_TCCR, 8'h01);
    idleCycles(2);
    ioRead(A_OCR, d);
    checkOutput("pre_reset_rdt", d, 8'h03);
    checkOutput("pre_reset_irq", {6'b0, irq_req}, 8'h02);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rdt", io_rdt, 8'h00);
    checkOutput("async_irq", {6'b0, irq_req}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(3);
    ioRead(A_TCNT, d);
    checkOutput("post_reset_tcnt", d, 8'h00);
    ioRead(A_TCCR, d);
    checkOutput("post_reset_tccr", d, 8'h00);
    ioRead(A_TIFR, d);
    checkOutput("post_reset_tifr", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
